// File: rtl/csa_4sub_pipe_pkg.sv
// Shared constants and elaboration checks for the four-operand carry-save subtractor.
package csa_4sub_pipe_pkg;

   localparam int unsigned MaxStage  = 3;
   localparam int unsigned GuardBits = 2;

   function automatic bit legal_width(int unsigned w);
      return (w == 4) || (w == 8) || (w == 16) || (w == 32);
   endfunction

   // Internal signed width: one guard bit for the overflow range, one for the sign.
   function automatic int unsigned int_width(int unsigned w);
      return w + GuardBits;
   endfunction

   function automatic bit legal_stage(int unsigned s);
      return s <= MaxStage;
   endfunction

endpackage

// File: rtl/csa_4sub_pipe_if.sv
// Operand/result bundle with valid/ready handshakes for csa_4sub_pipe.
interface csa_4sub_pipe_if #(
   parameter int unsigned Width = 32
);
   logic             i_vld;
   logic             o_rdy;
   logic             i_bw;
   logic [Width-1:0] i_y;
   logic [Width-1:0] i_z;
   logic [Width-1:0] i_a;
   logic [Width-1:0] i_b;
   logic             o_vld;
   logic             i_rdy;
   logic [Width-1:0] o_d;
   logic             o_neg;
   logic             o_ovf;

   modport master (
      output i_vld, i_bw, i_y, i_z, i_a, i_b, i_rdy,
      input  o_rdy, o_vld, o_d, o_neg, o_ovf
   );

   modport slave (
      input  i_vld, i_bw, i_y, i_z, i_a, i_b, i_rdy,
      output o_rdy, o_vld, o_d, o_neg, o_ovf
   );
endinterface

// File: rtl/csa_sub_pipe_stage.sv
// One valid/ready register slice; accepts when empty or when its contents leave this cycle.
module csa_sub_pipe_stage #(
   parameter int unsigned DataWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 vld_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 rdy_o,
   output logic                 vld_o,
   output logic [DataWidth-1:0] data_o,
   input  logic                 rdy_i
);

   logic                 vld_q;
   logic [DataWidth-1:0] data_q;

   always_comb begin
      rdy_o  = !vld_q || rdy_i;
      vld_o  = vld_q;
      data_o = data_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else if (rdy_o) begin
         vld_q <= vld_i;
         if (vld_i) begin
            data_q <= data_i;
         end
      end
   end

endmodule

// File: rtl/csa_4sub_pipe.sv
// Pipelined y + z - a - b - bw via a 4:2 carry-save stage and a final carry-propagate add.
// Define CSA_SUB_SATURATE_EN to clamp o_d to 0 / all-ones on underflow / overflow.
module csa_4sub_pipe
   import csa_4sub_pipe_pkg::*;
#(
   parameter int unsigned Width = 32,
   parameter int unsigned Stage = 2
) (
   input  logic           i_clkp,
   input  logic           i_rst,
   csa_4sub_pipe_if.slave bus
);

   localparam int unsigned IW = int_width(Width);

   if (!legal_width(Width) || !legal_stage(Stage) || ($bits(bus.i_y) != Width)) begin : g_bad_param
      $error("csa_4sub_pipe: illegal Width/Stage or interface width mismatch");
   end

   logic [IW-1:0] y_x, z_x, a_n, b_n;
   logic [IW-1:0] s1, c1, s2, c2;
   logic [IW-2:0] m1, m2;

   // Correction 2 - bw rides in the free carry LSBs: 1 in c1, !bw in c2.
   always_comb begin
      y_x = IW'(bus.i_y);
      z_x = IW'(bus.i_z);
      a_n = ~IW'(bus.i_a);
      b_n = ~IW'(bus.i_b);
      s1  = y_x ^ z_x ^ a_n;
      m1  = (y_x[IW-2:0] & z_x[IW-2:0]) | (y_x[IW-2:0] & a_n[IW-2:0]) |
            (z_x[IW-2:0] & a_n[IW-2:0]);
      c1  = {m1, 1'b1};
      s2  = s1 ^ c1 ^ b_n;
      m2  = (s1[IW-2:0] & c1[IW-2:0]) | (s1[IW-2:0] & b_n[IW-2:0]) |
            (c1[IW-2:0] & b_n[IW-2:0]);
      c2  = {m2, !bus.i_bw};
   end

   logic [IW-1:0] cs_s, cs_c;
   logic          cs_vld, cs_rdy;

   if (Stage == 0) begin : g_cs_comb
      assign cs_s      = s2;
      assign cs_c      = c2;
      assign cs_vld    = bus.i_vld;
      assign bus.o_rdy = cs_rdy;
   end else begin : g_cs_reg
      logic [2*IW-1:0] cs_q;

      csa_sub_pipe_stage #(
         .DataWidth(2 * IW)
      ) u_stage1 (
         .clk_i (i_clkp),
         .rst_i (i_rst),
         .vld_i (bus.i_vld),
         .data_i({s2, c2}),
         .rdy_o (bus.o_rdy),
         .vld_o (cs_vld),
         .data_o(cs_q),
         .rdy_i (cs_rdy)
      );

      assign cs_s = cs_q[2*IW-1:IW];
      assign cs_c = cs_q[IW-1:0];
   end

   logic [IW-1:0]    r;
   logic [Width-1:0] res_d;
   logic             res_neg, res_ovf;
   logic [Width+1:0] res_w;

   always_comb begin
      r       = cs_s + cs_c;
      res_neg = r[IW-1];
      res_ovf = !r[IW-1] && r[IW-2];
      res_d   = r[Width-1:0];
`ifdef CSA_SUB_SATURATE_EN
      if (res_neg) begin
         res_d = '0;
      end else if (res_ovf) begin
         res_d = '1;
      end
`endif
      res_w = {res_neg, res_ovf, res_d};
   end

   if (Stage <= 1) begin : g_res_comb
      assign bus.o_vld = cs_vld;
      assign cs_rdy    = bus.i_rdy;
      assign bus.o_neg = res_w[Width+1];
      assign bus.o_ovf = res_w[Width];
      assign bus.o_d   = res_w[Width-1:0];
   end else begin : g_res_reg
      // Index 0 is the resolved result entering the chain, Stage-1 the output slice.
      logic [Stage-1:0]              vld_c;
      logic [Stage-1:0]              rdy_c;
      logic [Stage-1:0][Width+1:0]   dat_c;

      assign vld_c[0]        = cs_vld;
      assign dat_c[0]        = res_w;
      assign cs_rdy          = rdy_c[0];
      assign rdy_c[Stage-1]  = bus.i_rdy;

      for (genvar k = 0; k < Stage - 1; k++) begin : g_slice
         csa_sub_pipe_stage #(
            .DataWidth(Width + 2)
         ) u_stage (
            .clk_i (i_clkp),
            .rst_i (i_rst),
            .vld_i (vld_c[k]),
            .data_i(dat_c[k]),
            .rdy_o (rdy_c[k]),
            .vld_o (vld_c[k+1]),
            .data_o(dat_c[k+1]),
            .rdy_i (rdy_c[k+1])
         );
      end

      assign bus.o_vld = vld_c[Stage-1];
      assign bus.o_neg = dat_c[Stage-1][Width+1];
      assign bus.o_ovf = dat_c[Stage-1][Width];
      assign bus.o_d   = dat_c[Stage-1][Width-1:0];
   end

endmodule

// File: tb/tb_csa_4sub_pipe.sv
// Directed bench for csa_4sub_pipe: Width=8 with Stage=2 and a Stage=0 instance.
module tb_csa_4sub_pipe;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   csa_4sub_pipe_if #(.Width(W)) bus ();
   csa_4sub_pipe_if #(.Width(W)) bus0 ();

   csa_4sub_pipe #(
      .Width(W),
      .Stage(2)
   ) u_dut (
      .i_clkp(clk),
      .i_rst (rst),
      .bus   (bus)
   );

   csa_4sub_pipe #(
      .Width(W),
      .Stage(0)
   ) u_dut0 (
      .i_clkp(clk),
      .i_rst (rst),
      .bus   (bus0)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.i_vld = 0; bus.i_rdy = 1; bus.i_bw = 0;
      bus.i_y = '0; bus.i_z = '0; bus.i_a = '0; bus.i_b = '0;
      bus0.i_vld = 0; bus0.i_rdy = 1; bus0.i_bw = 0;
      bus0.i_y = '0; bus0.i_z = '0; bus0.i_a = '0; bus0.i_b = '0;
      #3;
      checks++;
      if (bus.o_vld !== 1'b0) begin
         errors++; $display("FAIL reset_vld got %b want 0", bus.o_vld);
      end
      checks++;
      if (bus.o_d !== 8'h00) begin
         errors++; $display("FAIL reset_d got %h want 00", bus.o_d);
      end
      checks++;
      if (bus.o_neg !== 1'b0 || bus.o_ovf !== 1'b0) begin
         errors++; $display("FAIL reset_flags got neg=%b ovf=%b want 0 0", bus.o_neg, bus.o_ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.o_rdy !== 1'b1) begin
         errors++; $display("FAIL reset_rdy got %b want 1", bus.o_rdy);
      end
      tick();
   endtask

   task automatic test_arith;
      logic [W-1:0] vy [4];
      logic [W-1:0] vz [4];
      logic [W-1:0] va [4];
      logic [W-1:0] vb [4];
      logic         vbw [4];
      logic [W-1:0] ed [4];
      logic         en [4];
      logic         eo [4];
      vy = '{8'd10, 8'd0, 8'd255, 8'd0};
      vz = '{8'd20, 8'd0, 8'd255, 8'd0};
      va = '{8'd5, 8'd1, 8'd0, 8'd255};
      vb = '{8'd3, 8'd0, 8'd0, 8'd255};
      vbw = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef CSA_SUB_SATURATE_EN
      ed = '{8'd22, 8'h00, 8'hFF, 8'h00};
`else
      ed = '{8'd22, 8'hFF, 8'hFE, 8'h01};
`endif
      en = '{1'b0, 1'b1, 1'b0, 1'b1};
      eo = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         bus.i_y = vy[i]; bus.i_z = vz[i]; bus.i_a = va[i]; bus.i_b = vb[i];
         bus.i_bw = vbw[i]; bus.i_rdy = 1'b1; bus.i_vld = 1'b1;
         tick();
         bus.i_vld = 1'b0;
         #1;
         checks++;
         if (bus.o_vld !== 1'b0) begin
            errors++; $display("FAIL arith%0d_early_vld got %b want 0", i, bus.o_vld);
         end
         tick();
         checks++;
         if (bus.o_vld !== 1'b1) begin
            errors++; $display("FAIL arith%0d_vld got %b want 1", i, bus.o_vld);
         end
         checks++;
         if (bus.o_d !== ed[i]) begin
            errors++; $display("FAIL arith%0d_d got %h want %h", i, bus.o_d, ed[i]);
         end
         checks++;
         if (bus.o_neg !== en[i] || bus.o_ovf !== eo[i]) begin
            errors++;
            $display("FAIL arith%0d_flags got neg=%b ovf=%b want neg=%b ovf=%b",
                     i, bus.o_neg, bus.o_ovf, en[i], eo[i]);
         end
         tick();
      end
   endtask

   task automatic test_stall;
      int           sent = 0;
      int           recv = 0;
      int           cyc = 0;
      bit           held = 0;
      bit           saw_full = 0;
      logic [W-1:0] held_d = '0;
      bus.i_z = 8'd1; bus.i_a = '0; bus.i_b = '0; bus.i_bw = 1'b0;
      while (recv < 5 && cyc < 40) begin
         bus.i_rdy = !(cyc >= 2 && cyc <= 5);
         bus.i_vld = (sent < 5);
         bus.i_y   = W'(10 * sent);
         #1;
         if (held) begin
            checks++;
            if (bus.o_vld !== 1'b1 || bus.o_d !== held_d) begin
               errors++;
               $display("FAIL stall_hold got vld=%b d=%h want vld=1 d=%h", bus.o_vld, bus.o_d,
                        held_d);
            end
         end
         if (bus.i_vld && !bus.o_rdy && !saw_full) begin
            saw_full = 1;
            checks++;
            if (sent - recv != 2) begin
               errors++; $display("FAIL stall_full_depth got %0d want 2", sent - recv);
            end
         end
         if (bus.o_vld && bus.i_rdy) begin
            checks++;
            if (bus.o_d !== W'(10 * recv + 1)) begin
               errors++;
               $display("FAIL stall_order%0d got %h want %h", recv, bus.o_d, W'(10 * recv + 1));
            end
            recv++;
         end
         held   = bus.o_vld && !bus.i_rdy;
         held_d = bus.o_d;
         if (bus.i_vld && bus.o_rdy) sent++;
         cyc++;
         tick();
      end
      bus.i_vld = 1'b0;
      checks++;
      if (recv != 5) begin
         errors++; $display("FAIL stall_count got %0d want 5", recv);
      end
      checks++;
      if (!saw_full) begin
         errors++; $display("FAIL stall_rdy_low got 0 want 1");
      end
      checks++;
      if (bus.o_vld !== 1'b0) begin
         errors++; $display("FAIL stall_no_dup got vld=%b want 0", bus.o_vld);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      bus.i_rdy = 1'b0; bus.i_z = '0; bus.i_a = '0; bus.i_b = '0; bus.i_bw = 1'b0;
      bus.i_vld = 1'b1; bus.i_y = 8'd50;
      tick();
      bus.i_y = 8'd60;
      tick();
      bus.i_vld = 1'b0;
      checks++;
      if (bus.o_vld !== 1'b1 || bus.o_d !== 8'd50) begin
         errors++; $display("FAIL rstmid_pre got vld=%b d=%h want vld=1 d=32", bus.o_vld, bus.o_d);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.o_vld !== 1'b0 || bus.o_d !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_clear got vld=%b d=%h want vld=0 d=00", bus.o_vld, bus.o_d);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.i_rdy = 1'b1; bus.i_vld = 1'b1; bus.i_y = 8'd7;
      tick();
      bus.i_vld = 1'b0;
      #1;
      checks++;
      if (bus.o_vld !== 1'b0) begin
         errors++; $display("FAIL rstmid_early got vld=%b want 0", bus.o_vld);
      end
      tick();
      checks++;
      if (bus.o_vld !== 1'b1 || bus.o_d !== 8'd7) begin
         errors++; $display("FAIL rstmid_post got vld=%b d=%h want vld=1 d=07", bus.o_vld, bus.o_d);
      end
      tick();
   endtask

   task automatic test_comb;
      bus0.i_y = 8'd10; bus0.i_z = 8'd20; bus0.i_a = 8'd5; bus0.i_b = 8'd3; bus0.i_bw = 1'b0;
      bus0.i_rdy = 1'b1; bus0.i_vld = 1'b0;
      #1;
      checks++;
      if (bus0.o_vld !== 1'b0) begin
         errors++; $display("FAIL comb_vld_lo got %b want 0", bus0.o_vld);
      end
      bus0.i_vld = 1'b1;
      #1;
      checks++;
      if (bus0.o_vld !== 1'b1 || bus0.o_d !== 8'd22) begin
         errors++; $display("FAIL comb_result got vld=%b d=%h want vld=1 d=16", bus0.o_vld, bus0.o_d);
      end
      bus0.i_rdy = 1'b0;
      #1;
      checks++;
      if (bus0.o_rdy !== 1'b0) begin
         errors++; $display("FAIL comb_rdy_lo got %b want 0", bus0.o_rdy);
      end
      bus0.i_rdy = 1'b1;
      #1;
      checks++;
      if (bus0.o_rdy !== 1'b1) begin
         errors++; $display("FAIL comb_rdy_hi got %b want 1", bus0.o_rdy);
      end
      bus0.i_vld = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_arith();
      test_stall();
      test_reset_mid();
      test_comb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
